// File: rtl/if_fetch.sv
`timescale 1ns/1ps
// Instruction fetch: owns the PC, keeps one imem request outstanding, buffers the response for decode.
// Best case 3 cycles per instruction; decode stalls via id_ready hold the buffer and block new requests.
module if_fetch #(
  parameter int                   CPU_WIDTH  = 64,
  parameter int                   INST_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [CPU_WIDTH-1:0]  next_pc,
  input  logic                  redirect,
  output logic [CPU_WIDTH-1:0]  curr_pc,
  output logic                  imem_req_valid,
  output logic [CPU_WIDTH-1:0]  imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_inst,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [CPU_WIDTH-1:0]  if_pc,
  input  logic                  id_ready
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                r_state;
  logic [CPU_WIDTH-1:0]  r_pc;
  logic                  r_drop;
  logic                  r_req_vld;
  logic                  r_if_vld;
  logic [INST_WIDTH-1:0] r_if_inst;
  logic [CPU_WIDTH-1:0]  r_if_pc;

  logic [CPU_WIDTH-1:0]  w_npc;
  logic                  w_unused_lsb;

  // Fetch addresses are word aligned; the low bits of next_pc are ignored.
  assign w_npc        = {next_pc[CPU_WIDTH-1:2], 2'b00};
  assign w_unused_lsb = ^next_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_drop    <= 1'b0;
      r_req_vld <= 1'b0;
      r_if_vld  <= 1'b0;
      r_if_inst <= '0;
      r_if_pc   <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) begin
            r_pc <= w_npc;
          end else if (ena) begin
            r_state   <= S_REQ;
            r_req_vld <= 1'b1;
          end
        end
        S_REQ: begin
          if (redirect) r_pc <= w_npc;
          if (imem_req_ready) begin
            // A redirect coinciding with acceptance orphans the accepted request.
            r_state   <= S_WAIT;
            r_req_vld <= 1'b0;
            r_drop    <= redirect;
          end else if (!ena) begin
            r_state   <= S_IDLE;
            r_req_vld <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_drop <= 1'b0;
            if (r_drop || redirect) begin
              if (redirect) r_pc <= w_npc;
              r_state   <= ena ? S_REQ : S_IDLE;
              r_req_vld <= ena;
            end else begin
              r_if_inst <= imem_rsp_inst;
              r_if_pc   <= r_pc;
              r_if_vld  <= 1'b1;
              r_state   <= S_HOLD;
            end
          end else if (redirect) begin
            r_pc   <= w_npc;
            r_drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc      <= w_npc;
            r_if_vld  <= 1'b0;
            r_state   <= S_REQ;
            r_req_vld <= 1'b1;
          end else if (id_ready) begin
            r_pc      <= w_npc;
            r_if_vld  <= 1'b0;
            r_state   <= ena ? S_REQ : S_IDLE;
            r_req_vld <= ena;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_req_vld <= 1'b0;
          r_if_vld  <= 1'b0;
        end
      endcase
    end
  end

  assign curr_pc        = r_pc;
  assign imem_req_addr  = r_pc;
  assign imem_req_valid = r_req_vld;
  assign if_valid       = r_if_vld;
  assign if_inst        = r_if_inst;
  assign if_pc          = r_if_pc;

endmodule

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
// Bench for if_fetch: directed scenarios plus a randomized run checked against a program-order model.
module tb_if_fetch;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, ena, redirect, imem_req_ready, imem_rsp_valid, id_ready;
  logic [63:0] tgt, next_pc, curr_pc, imem_req_addr, if_pc;
  logic [31:0] imem_rsp_inst, if_inst;
  logic        imem_req_valid, if_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Selector stand-in: sequential +4 unless a redirect target is offered.
  assign next_pc = redirect ? tgt : curr_pc + 64'd4;

  if_fetch #(.CPU_WIDTH(64), .INST_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .next_pc(next_pc), .redirect(redirect),
    .curr_pc(curr_pc), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_inst(imem_rsp_inst), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .id_ready(id_ready)
  );

  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ena = 0; redirect = 0; tgt = '0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_inst = '0; id_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1;
    step(); step();
    rst_n = 0;
    #2;
    n_cmp++; if (curr_pc !== RPC) begin n_err++; $display("FAIL reset_curr_pc got %h want %h", curr_pc, RPC); end
    n_cmp++; if (imem_req_addr !== RPC) begin n_err++; $display("FAIL reset_req_addr got %h want %h", imem_req_addr, RPC); end
    n_cmp++; if (if_pc !== RPC) begin n_err++; $display("FAIL reset_if_pc got %h want %h", if_pc, RPC); end
    n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL reset_if_inst got %h want 0", if_inst); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
    step();
    rst_n = 1;
    step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_req got %b want 0", imem_req_valid); end
  endtask

  task automatic test_basic_and_stall();
    logic [63:0] hpc;
    logic [31:0] hinst;
    do_reset();
    ena = 1; imem_req_ready = 1;
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin n_err++; $display("FAIL basic_req1 got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RPC); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait_novalid got %b want 0", imem_req_valid); end
    imem_rsp_valid = 1; imem_rsp_inst = 32'h0000_0013;
    step();
    imem_rsp_valid = 0; imem_rsp_inst = 32'hFFFF_FFFF;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== RPC || if_inst !== 32'h13) begin n_err++; $display("FAIL basic_hold got v=%b pc=%h i=%h want v=1 pc=%h i=00000013", if_valid, if_pc, if_inst, RPC); end
    hpc = if_pc; hinst = if_inst;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== hpc || if_inst !== hinst || imem_req_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_hold cyc%0d got v=%b pc=%h i=%h rq=%b want v=1 pc=%h i=%h rq=0", k, if_valid, if_pc, if_inst, imem_req_valid, hpc, hinst);
      end
    end
    id_ready = 1;
    step();
    id_ready = 0;
    n_cmp++; if (curr_pc !== RPC + 64'd4) begin n_err++; $display("FAIL fire_curr_pc got %h want %h", curr_pc, RPC + 64'd4); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC + 64'd4 || if_valid !== 1'b0) begin n_err++; $display("FAIL fire_next_req got rq=%b a=%h v=%b want rq=1 a=%h v=0", imem_req_valid, imem_req_addr, if_valid, RPC + 64'd4); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    ena = 1; imem_req_ready = 1;
    step(); step();
    redirect = 1; tgt = 64'h8000_0100;
    step();
    redirect = 0;
    n_cmp++; if (curr_pc !== 64'h8000_0100 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdw_pc got pc=%h rq=%b want pc=80000100 rq=0", curr_pc, imem_req_valid); end
    imem_rsp_valid = 1; imem_rsp_inst = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rdw_discard got if_valid=%b want 0", if_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin n_err++; $display("FAIL rdw_newreq got rq=%b a=%h want rq=1 a=80000100", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    ena = 1; imem_req_ready = 1;
    step(); step();
    imem_rsp_valid = 1; imem_rsp_inst = 32'h1111_2222;
    step();
    imem_rsp_valid = 0;
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rdh_reach_hold got %b want 1", if_valid); end
    id_ready = 1; redirect = 1; tgt = 64'h8000_0200;
    step();
    id_ready = 0; redirect = 0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rdh_valid_drop got %b want 0", if_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin n_err++; $display("FAIL rdh_target got rq=%b a=%h want rq=1 a=80000200", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stall_ena();
    do_reset();
    ena = 1; imem_req_ready = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin n_err++; $display("FAIL req_stall cyc%0d got rq=%b a=%h want rq=1 a=%h", k, imem_req_valid, imem_req_addr, RPC); end
      step();
    end
    ena = 0;
    step();
    n_cmp++; if (imem_req_valid !== 1'b0 || curr_pc !== RPC) begin n_err++; $display("FAIL ena_abort got rq=%b pc=%h want rq=0 pc=%h", imem_req_valid, curr_pc, RPC); end
    redirect = 1; tgt = 64'h8000_0103;
    step();
    redirect = 0;
    n_cmp++; if (curr_pc !== 64'h8000_0100 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL idle_redirect_align got pc=%h rq=%b want pc=80000100 rq=0", curr_pc, imem_req_valid); end
    ena = 1;
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin n_err++; $display("FAIL idle_resume got rq=%b a=%h want rq=1 a=80000100", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_wait();
    do_reset();
    ena = 1; imem_req_ready = 1;
    step();
    redirect = 1; tgt = 64'h8000_0300;
    step();
    redirect = 0; ena = 0;
    n_cmp++; if (curr_pc !== 64'h8000_0300 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rstw_accept_redirect got pc=%h rq=%b want pc=80000300 rq=0", curr_pc, imem_req_valid); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (curr_pc !== RPC || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL rstw_async got pc=%h rq=%b v=%b want pc=%h rq=0 v=0", curr_pc, imem_req_valid, if_valid, RPC); end
    step();
    rst_n = 1; imem_rsp_valid = 1; imem_rsp_inst = 32'hCAFE_0001;
    step();
    imem_rsp_valid = 0;
    n_cmp++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rstw_late_rsp got v=%b rq=%b want v=0 rq=0", if_valid, imem_req_valid); end
  endtask

  // Model: fired instructions must follow program order (+4 per fire, jump on redirect)
  // and carry the memory word of their PC; at most one request outstanding.
  task automatic test_random();
    logic [63:0] exp_pc, maddr, hpc;
    logic [31:0] hinst;
    logic        busy, hold_prev, acc, fire;
    int          cnt, n_fire;
    do_reset();
    exp_pc = RPC; busy = 0; cnt = 0; n_fire = 0; hold_prev = 0; maddr = '0; hpc = '0; hinst = '0;
    for (int c = 0; c < 4000; c++) begin
      n_cmp++; if (imem_req_addr !== curr_pc || curr_pc[1:0] !== 2'b00) begin n_err++; $display("FAIL rnd_addr c%0d got a=%h pc=%h want equal and aligned", c, imem_req_addr, curr_pc); end
      if (busy) begin
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rnd_outstanding c%0d got rq=%b want 0", c, imem_req_valid); end
      end
      if (hold_prev) begin
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== hpc || if_inst !== hinst) begin n_err++; $display("FAIL rnd_hold c%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h", c, if_valid, if_pc, if_inst, hpc, hinst); end
      end
      ena            = ($urandom_range(0, 9) != 0);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      id_ready       = ($urandom_range(0, 9) < 6);
      redirect       = ($urandom_range(0, 12) == 0);
      tgt            = {32'h0, 32'h8000_0000 | $urandom_range(0, 32'hFFFF)};
      if (busy && cnt == 0) begin
        imem_rsp_valid = 1; imem_rsp_inst = memf(maddr); busy = 0;
      end else begin
        imem_rsp_valid = 0; imem_rsp_inst = $urandom;
        if (busy) cnt--;
      end
      acc  = imem_req_valid && imem_req_ready;
      fire = if_valid && id_ready && !redirect;
      if (fire) begin
        n_cmp++; if (if_pc !== exp_pc || if_inst !== memf(exp_pc)) begin n_err++; $display("FAIL rnd_fire c%0d got pc=%h i=%h want pc=%h i=%h", c, if_pc, if_inst, exp_pc, memf(exp_pc)); end
        n_fire++;
        exp_pc = exp_pc + 64'd4;
      end
      if (redirect) exp_pc = {tgt[63:2], 2'b00};
      if (acc) begin busy = 1; maddr = imem_req_addr; cnt = $urandom_range(0, 2); end
      hold_prev = if_valid && !fire && !redirect;
      hpc = if_pc; hinst = if_inst;
      step();
    end
    n_cmp++; if (n_fire < 50) begin n_err++; $display("FAIL rnd_progress got %0d fires want >= 50", n_fire); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_and_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_stall_ena();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
